// File: rtl/gouram_trace_serialiser_if.sv
// Output stream of the gouram trace serialiser: 32-bit valid/ready beats with a last flag.
interface gouram_trace_serialiser_if;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        out_ready_i;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/gouram_trace_serialiser.sv
// Buffers whole gouram trace records and serialises each as one header beat
// ({seq, drop_cnt}) followed by ceil(TRACE_WIDTH/32) payload beats, LSW first.
module gouram_trace_serialiser #(
    parameter int unsigned TRACE_WIDTH = 128,
    parameter int unsigned FIFO_DEPTH  = 8,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trace_valid_i,
    input  logic [TRACE_WIDTH-1:0]     trace_data_i,
    gouram_trace_serialiser_if.master  stream_if,
    output logic [LVL_W-1:0]           fifo_level_o,
    output logic                       overflow_o
);

    localparam int unsigned BEATS  = (TRACE_WIDTH + 31) / 32;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PAD_W  = BEATS * 32;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [LVL_W-1:0]  LvlFull  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LvlOne   = LVL_W'(1);
    localparam logic [BEAT_W-1:0] BeatLast = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

    logic [TRACE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [LVL_W-1:0]       level_q;
    logic [LVL_W-1:0]       level_d;

    state_e                 state_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [BEAT_W-1:0]      beat_nxt;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic [31:0]            out_data_q;
    logic                   overflow_q;
    logic [15:0]            seq_q;
    logic [15:0]            drop_q;
    logic [15:0]            drop_d;

    logic                   push;
    logic                   drop;
    logic                   hs;
    logic                   hdr_hs;
    logic                   pop;
    logic [PAD_W-1:0]       head_pad;
    logic [31:0]            word_first;
    logic [31:0]            word_next;
    logic [31:0]            header_word;

    // Handshake decode, FIFO level and drop counter next-state, beat word selection.
    always_comb begin
        // Full is judged on the registered level only, so a same-edge pop never frees a slot.
        push   = trace_valid_i && (level_q != LvlFull);
        drop   = trace_valid_i && (level_q == LvlFull);
        hs     = out_valid_q && stream_if.out_ready_i;
        hdr_hs = hs && (state_q == StHeader);
        pop    = hs && (state_q == StPayload) && out_last_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LvlOne;
        end else if (pop && !push) begin
            level_d = level_q - LvlOne;
        end

        drop_d = drop_q;
        if (hdr_hs) begin
            drop_d = {15'd0, drop};
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        head_pad    = PAD_W'(mem_q[rd_ptr_q]);
        beat_nxt    = beat_q + 1'b1;
        word_first  = head_pad[31:0];
        word_next   = head_pad[32*beat_nxt +: 32];
        header_word = {seq_q, drop_d};
    end

    // Record storage; the head entry stays put until its final beat is accepted.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= trace_data_i;
        end
    end

    // FIFO pointers and level; pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    // Drop counter and the one-cycle overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            drop_q     <= drop_d;
            overflow_q <= drop;
        end
    end

    // Framing FSM with registered stream outputs and the sequence counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            beat_q      <= '0;
            seq_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (level_q != '0) begin
                        state_q     <= StHeader;
                        out_valid_q <= 1'b1;
                        out_data_q  <= header_word;
                    end
                end
                StHeader: begin
                    if (hs) begin
                        state_q    <= StPayload;
                        beat_q     <= '0;
                        seq_q      <= seq_q + 16'd1;
                        out_data_q <= word_first;
                        out_last_q <= (BEATS == 1);
                    end else begin
                        // Keep the drop field current so drops seen while stalled are reported.
                        out_data_q <= header_word;
                    end
                end
                StPayload: begin
                    if (hs) begin
                        if (out_last_q) begin
                            out_last_q <= 1'b0;
                            if (level_q > LvlOne) begin
                                state_q    <= StHeader;
                                out_data_q <= header_word;
                            end else begin
                                state_q     <= StIdle;
                                out_valid_q <= 1'b0;
                                out_data_q  <= '0;
                            end
                        end else begin
                            beat_q     <= beat_nxt;
                            out_data_q <= word_next;
                            out_last_q <= (beat_nxt == BeatLast);
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    out_data_q  <= '0;
                end
            endcase
        end
    end

    assign stream_if.out_valid_o = out_valid_q;
    assign stream_if.out_data_o  = out_data_q;
    assign stream_if.out_last_o  = out_last_q;
    assign fifo_level_o          = level_q;
    assign overflow_o            = overflow_q;

endmodule

// File: tb/tb_gouram_trace_serialiser.sv
// Self-checking bench for gouram_trace_serialiser: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_gouram_trace_serialiser;

    localparam int unsigned TW    = 128;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned BEATS = (TW + 31) / 32;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              trace_valid_i;
    logic [TW-1:0]     trace_data_i;
    logic [LVL_W-1:0]  fifo_level_o;
    logic              overflow_o;

    gouram_trace_serialiser_if sif ();

    gouram_trace_serialiser #(
        .TRACE_WIDTH (TW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trace_valid_i (trace_valid_i),
        .trace_data_i  (trace_data_i),
        .stream_if     (sif),
        .fifo_level_o  (fifo_level_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: records queued, position in the current frame
    // (-1 idle, 0 header, k>0 payload word k-1), counters.
    logic [TW-1:0] mq [$];
    int            pos    = -1;
    int            seq_m  = 0;
    int            drop_m = 0;
    bit            ovf_m  = 1'b0;

    typedef struct {
        bit          tv;
        bit          rdy;
        bit          e_valid;
        logic [31:0] e_data;
        bit          e_last;
        int          e_level;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] rand_rec();
        logic [BEATS*32-1:0] tmp;
        for (int i = 0; i < int'(BEATS); i++) begin
            tmp[i*32 +: 32] = $urandom;
        end
        return tmp[TW-1:0];
    endfunction

    function automatic logic [31:0] exp_data();
        logic [TW+31:0] wide;
        if (pos == 0) return {seq_m[15:0], drop_m[15:0]};
        if (pos > 0) begin
            wide = {32'd0, mq[0]};
            wide = wide >> (32 * (pos - 1));
            return wide[31:0];
        end
        return 32'd0;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_edge(input bit tv, input logic [TW-1:0] td, input bit rdy, input bit r);
        bit hs;
        bit full;
        bit dropped;
        int old_size;
        if (r) begin
            mq.delete();
            pos    = -1;
            seq_m  = 0;
            drop_m = 0;
            ovf_m  = 1'b0;
            return;
        end
        hs       = (pos >= 0) && rdy;
        old_size = mq.size();
        full     = (old_size == int'(DEPTH));
        dropped  = tv && full;
        if (hs && pos == 0) begin
            seq_m  = (seq_m + 1) % 65536;
            drop_m = dropped ? 1 : 0;
        end else if (dropped && drop_m < 65535) begin
            drop_m++;
        end
        ovf_m = dropped;
        if (pos < 0) begin
            if (old_size != 0) pos = 0;
        end else if (hs) begin
            if (pos < int'(BEATS)) begin
                pos++;
            end else begin
                pos = (old_size > 1) ? 0 : -1;
                void'(mq.pop_front());
            end
        end
        if (tv && !full) mq.push_back(td);
    endtask

    task automatic check_model();
        chk("model_valid", sif.out_valid_o, pos >= 0);
        if (pos >= 0) begin
            chk("model_data", sif.out_data_o, exp_data());
            chk("model_last", sif.out_last_o, pos == int'(BEATS));
        end
        chk("model_level", fifo_level_o, mq.size());
        chk("model_overflow", overflow_o, ovf_m);
    endtask

    // Drive inputs at the falling edge, cross one rising edge, check at the next falling edge.
    task automatic step(input bit tv, input logic [TW-1:0] td, input bit rdy, input bit r);
        trace_valid_i   = tv;
        trace_data_i    = td;
        sif.out_ready_i = rdy;
        rst             = r;
        model_edge(tv, td, rdy, r);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [TW-1:0] rec;
        logic [31:0]   prev_data;
        bit            prev_valid;
        bit            prev_last;
        bit            prev_rdy;
        bit            rdy;
        bit            found;
        int            beats;
        int            lasts;
        int            ovf_cnt;
        int            bias;
        int            tvb;

        rec = 128'h44444444_33333333_22222222_11111111;
        //            tv rdy valid data          last level
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h00000000, 1'b0, 1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h22222222, 1'b0, 1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h33333333, 1'b0, 1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h44444444, 1'b1, 1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 0};

        rst             = 1'b1;
        trace_valid_i   = 1'b0;
        trace_data_i    = '0;
        sif.out_ready_i = 1'b0;
        @(negedge clk);

        // Reset state.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("rst_valid", sif.out_valid_o, 0);
        chk("rst_last", sif.out_last_o, 0);
        chk("rst_data", sif.out_data_o, 0);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_overflow", overflow_o, 0);

        // Single record, directed table.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].tv, rec, tbl[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_valid", i), sif.out_valid_o, tbl[i].e_valid);
            chk($sformatf("tbl%0d_level", i), fifo_level_o, tbl[i].e_level);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_data", i), sif.out_data_o, tbl[i].e_data);
                chk($sformatf("tbl%0d_last", i), sif.out_last_o, tbl[i].e_last);
            end
        end

        // Backpressure: ready toggles every cycle.
        beats    = 0;
        prev_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rdy        = i[0];
            prev_valid = sif.out_valid_o;
            prev_data  = sif.out_data_o;
            prev_last  = sif.out_last_o;
            prev_rdy   = rdy;
            if (sif.out_valid_o && rdy) beats++;
            step(i < 2, rand_rec(), rdy, 1'b0);
            if (prev_valid && !prev_rdy) begin
                chk("bp_hold_valid", sif.out_valid_o, 1);
                chk("bp_hold_data", sif.out_data_o, prev_data);
                chk("bp_hold_last", sif.out_last_o, prev_last);
            end
        end
        chk("bp_beats", beats, 2 * (BEATS + 1));
        chk("bp_level", fifo_level_o, 0);

        // Overflow: ten pushes into an eight-deep FIFO with the consumer stalled.
        step(1'b0, '0, 1'b0, 1'b1);
        ovf_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rand_rec(), 1'b0, 1'b0);
            ovf_cnt += int'(overflow_o);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        ovf_cnt += int'(overflow_o);
        chk("ovf_level", fifo_level_o, DEPTH);
        chk("ovf_pulses", ovf_cnt, 2);
        beats = 0;
        lasts = 0;
        for (int i = 0; i < 60; i++) begin
            if (sif.out_valid_o) begin
                if (beats % (BEATS + 1) == 0) begin
                    chk($sformatf("ovf_hdr%0d", beats / (BEATS + 1)), sif.out_data_o,
                        (beats == 0) ? 32'h00000002 : {16'(beats / (BEATS + 1)), 16'h0000});
                end
                if (sif.out_last_o) lasts++;
                beats++;
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("ovf_beats", beats, DEPTH * (BEATS + 1));
        chk("ovf_records", lasts, DEPTH);
        chk("ovf_drain_level", fifo_level_o, 0);

        // Push on the very edge of a final-beat pop while full.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < int'(DEPTH); i++) step(1'b1, rand_rec(), 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (sif.out_valid_o && sif.out_last_o) found = 1'b1;
            else step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("edge_found_last", found, 1);
        if (found) begin
            step(1'b1, rand_rec(), 1'b1, 1'b0);
            chk("edge_level", fifo_level_o, DEPTH - 1);
            chk("edge_overflow", overflow_o, 1);
        end

        // Back-to-back: three queued records drain with no idle cycle.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, rand_rec(), 1'b0, 1'b0);
        for (int i = 0; i < 3 * int'(BEATS + 1); i++) begin
            chk($sformatf("b2b_valid%0d", i), sif.out_valid_o, 1);
            if (i % (BEATS + 1) == 0) begin
                chk($sformatf("b2b_hdr%0d", i), sif.out_data_o, {16'(i / (BEATS + 1)), 16'h0000});
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("b2b_idle", sif.out_valid_o, 0);
        chk("b2b_level", fifo_level_o, 0);

        // Reset in the middle of a record.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, rec, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("mid_beat2", sif.out_data_o, 32'h33333333);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("mid_rst_valid", sif.out_valid_o, 0);
        chk("mid_rst_level", fifo_level_o, 0);
        step(1'b1, rec, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("mid_next_valid", sif.out_valid_o, 1);
        chk("mid_next_hdr", sif.out_data_o, 32'h00000000);

        // Randomized traffic with varying push density and consumer readiness.
        bias = 2;
        tvb  = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                bias = $urandom_range(0, 4);
                tvb  = $urandom_range(1, 3);
            end
            step($urandom_range(0, 3) < tvb, rand_rec(), $urandom_range(0, 3) < bias,
                 $urandom_range(0, 399) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
